gpio_in_debounce: RTL

- Input conditioning stage between the board's raw mechanical inputs (buttons, slide switches) and the SoC GPIO input vector.
- Synchronises each bit into the SoC clock domain and debounces it with a shared tick prescaler and per-bit stability counters.
- Produces clean levels plus one-cycle rise and fall pulses.
- The board shell instantiates it on btn/sw and drives the debounced levels into the corresponding io_gpio_i bits.

---
 rtl/zr_io_pkg.sv | 12 +
 rtl/debounce_bit.sv | 64 ++++++
 rtl/gpio_in_debounce.sv | 56 +++++
 3 files changed

// File: rtl/zr_io_pkg.sv
// Shared constants and helpers for the board I/O conditioning blocks.
package zr_io_pkg;

    localparam int DEBOUNCE_TICK_DIV_16M = 16000;
    localparam int DEBOUNCE_STABLE_TICKS_DEFAULT = 8;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: synchroniser, stability counter, debounced level
// and registered edge pulses.
module debounce_bit
    import zr_io_pkg::*;
#(
    parameter int   SYNC_STAGES  = 2,
    parameter int   STABLE_TICKS = DEBOUNCE_STABLE_TICKS_DEFAULT,
    parameter logic RST_VAL      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic tick,
    input  logic din,
    output logic dout,
    output logic rise_p,
    output logic fall_p
);

    localparam int CW = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CW-1:0]          cnt;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    // Any agreement between s and dout restarts qualification.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            dout   <= RST_VAL;
            rise_p <= 1'b0;
            fall_p <= 1'b0;
        end else begin
            rise_p <= 1'b0;
            fall_p <= 1'b0;
            if (!en) begin
                cnt <= '0;
            end else if (s == dout) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CNT_LAST) begin
                    dout   <= s;
                    cnt    <= '0;
                    rise_p <= s;
                    fall_p <= ~s;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gpio_in_debounce.sv
// Debounced GPIO input stage: shared tick prescaler feeding WIDTH
// independent per-bit debouncers.
module gpio_in_debounce
    import zr_io_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               SYNC_STAGES  = 2,
    parameter int               TICK_DIV     = DEBOUNCE_TICK_DIV_16M,
    parameter int               STABLE_TICKS = DEBOUNCE_STABLE_TICKS_DEFAULT,
    parameter logic [WIDTH-1:0] RST_VAL      = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise_p,
    output logic [WIDTH-1:0] fall_p
);

    localparam int PW = cnt_width(TICK_DIV - 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt;
    logic          tick;

    assign tick = en && (pcnt == PCNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (!en || pcnt == PCNT_LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS),
            .RST_VAL      (RST_VAL[i])
        ) u_bit (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .tick   (tick),
            .din    (din[i]),
            .dout   (dout[i]),
            .rise_p (rise_p[i]),
            .fall_p (fall_p[i])
        );
    end

endmodule
